// File: rtl/ccm_pkg.sv
// ccm_pkg: shared AHB encodings, 128-bit block type and FSM states for the CCM result sink.
package ccm_pkg;
    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_BUSY   = 2'd1;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;
    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;
    typedef logic [127:0] block_t;
    typedef enum logic [2:0] {IDLE, DATA, STALL, ERR1, ERR2} state_t;
    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] window);
        logic [32:0] lim;
        lim = {1'b0, base} + {1'b0, window};
        return addr >= base && {1'b0, addr} < lim && addr[3:0] == base[3:0];
    endfunction
endpackage

// File: rtl/ccm_result_slave_if.sv
// ccm_result_slave_if: AHB-style write bus between a master and the CCM result sink.
interface ccm_result_slave_if;
    import ccm_pkg::*;
    logic        HSEL;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [31:0] HADDR;
    block_t      HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    modport slave (input HSEL, HWRITE, HTRANS, HBURST, HADDR, HWDATA, HREADY, output HREADYOUT, HRESP);
    modport master (output HSEL, HWRITE, HTRANS, HBURST, HADDR, HWDATA, input HREADY, HREADYOUT, HRESP);
endinterface

// File: rtl/ccm_sink_fifo.sv
// ccm_sink_fifo: circular store of {address, data} entries with combinational head and occupancy count.
module ccm_sink_fifo
    import ccm_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic          pop,
    input  block_t        wr_data,
    input  logic [31:0]   wr_addr,
    output block_t        rd_data,
    output logic [31:0]   rd_addr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    block_t        data_mem [DEPTH];
    logic [31:0]   addr_mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          take;

    assign take    = pop && !empty;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign rd_data = empty ? '0 : data_mem[rp];
    assign rd_addr = empty ? '0 : addr_mem[rp];

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(take);
            count <= count + CW'(push) - CW'(take);
        end

    always_ff @(posedge clk)
        if (push) begin
            data_mem[wp] <= wr_data;
            addr_mem[wp] <= wr_addr;
        end
endmodule

// File: rtl/ccm_result_slave.sv
// ccm_result_slave: AHB write sink queuing {address, data} beats for a consumer; reads get a two-cycle ERROR.
// Define CCM_SINK_ADDR_CHECK_EN to also reject writes outside the BASE_ADDR/WINDOW range or off its 16-byte lane.
module ccm_result_slave
    import ccm_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1110,
    parameter logic [31:0] WINDOW    = 32'h0000_1000,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                n_rst,
    ccm_result_slave_if.slave   ahb,
    input  logic                rd_en,
    output block_t              rd_data,
    output logic [31:0]         rd_addr,
    output logic [CW-1:0]       count,
    output logic                empty,
    output logic                full
);
`ifdef CCM_SINK_ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif
    state_t      state, state_nx, start;
    logic        acc, wr_ok, push, in_data;
    logic [31:0] addr_q;
    logic [2:0]  burst_q_unused;

    assign acc     = ahb.HSEL && ahb.HREADY && (ahb.HTRANS == TRANS_NONSEQ || ahb.HTRANS == TRANS_SEQ);
    assign wr_ok   = ahb.HWRITE && (!CHECK || addr_ok(ahb.HADDR, BASE_ADDR, WINDOW));
    assign start   = !acc ? IDLE : wr_ok ? DATA : ERR1;
    assign in_data = state == DATA || state == STALL;
    // A full FIFO still takes the beat when the consumer pops in the same cycle.
    assign push    = in_data && (!full || rd_en);

    assign ahb.HREADYOUT = !(state == ERR1 || (in_data && !push));
    assign ahb.HRESP     = (state == ERR1 || state == ERR2) ? RESP_ERROR : RESP_OKAY;

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            addr_q         <= '0;
            burst_q_unused <= '0;
        end else if (acc) begin
            addr_q         <= ahb.HADDR;
            burst_q_unused <= ahb.HBURST;
        end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        state_nx = start;
            DATA, STALL: state_nx = push ? start : STALL;
            ERR1:        state_nx = ERR2;
            ERR2:        state_nx = start;
            default:     state_nx = IDLE;
        endcase
    end

    ccm_sink_fifo #(.DEPTH(DEPTH)) fifo (
        .clk    (clk),
        .n_rst  (n_rst),
        .push   (push),
        .pop    (rd_en),
        .wr_data(ahb.HWDATA),
        .wr_addr(addr_q),
        .rd_data(rd_data),
        .rd_addr(rd_addr),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );
endmodule
